// File: rtl/piezo_pkg.sv
// Shared constants for the piezo sound arbiter: tone words, melody ids and
// the per-melody start/length layout of the melody ROM.
package piezo_pkg;

    localparam int unsigned NUM_REQ = 4;

    localparam int unsigned TONE_C      = 478;
    localparam int unsigned TONE_D      = 424;
    localparam int unsigned TONE_DSHARP = 401;
    localparam int unsigned TONE_E      = 378;
    localparam int unsigned TONE_F      = 358;
    localparam int unsigned TONE_G      = 320;
    localparam int unsigned TONE_A      = 284;
    localparam int unsigned TONE_B      = 254;

    localparam logic [1:0] ID_CLICK    = 2'd0;
    localparam logic [1:0] ID_TIMEOVER = 2'd1;
    localparam logic [1:0] ID_SUCCESS  = 2'd2;
    localparam logic [1:0] ID_GAMEOVER = 2'd3;

    typedef enum logic [0:0] {StIdle, StPlay} arb_state_e;

    function automatic logic [5:0] mel_start(input logic [1:0] id);
        case (id)
            ID_CLICK:    return 6'd0;
            ID_TIMEOVER: return 6'd2;
            ID_SUCCESS:  return 6'd10;
            default:     return 6'd26;
        endcase
    endfunction

    function automatic logic [4:0] mel_len(input logic [1:0] id);
        case (id)
            ID_CLICK:    return 5'd2;
            ID_TIMEOVER: return 5'd8;
            ID_SUCCESS:  return 5'd16;
            default:     return 5'd8;
        endcase
    endfunction

endpackage

// File: rtl/piezo_melody_rom.sv
// Combinational melody ROM: 34 note words laid out back to back by melody id.
module piezo_melody_rom
#(
    parameter int unsigned NOTE_W = 10
) (
    input  logic [5:0]        i_addr,
    output logic [NOTE_W-1:0] o_note
);
    import piezo_pkg::*;

    always_comb begin
        o_note = '0;
        case (i_addr)
            6'd0:  o_note = NOTE_W'(TONE_B);
            6'd2:  o_note = NOTE_W'(TONE_B);
            6'd4:  o_note = NOTE_W'(TONE_B);
            6'd6:  o_note = NOTE_W'(TONE_B);
            6'd7:  o_note = NOTE_W'(TONE_B);
            6'd10: o_note = NOTE_W'(127);
            6'd12: o_note = NOTE_W'(127);
            6'd14: o_note = NOTE_W'(127);
            6'd15: o_note = NOTE_W'(127);
            6'd18: o_note = NOTE_W'(100);
            6'd20: o_note = NOTE_W'(127);
            6'd22: o_note = NOTE_W'(142);
            6'd24: o_note = NOTE_W'(160);
            6'd26: o_note = NOTE_W'(TONE_G);
            6'd27: o_note = NOTE_W'(TONE_F);
            6'd28: o_note = NOTE_W'(TONE_E);
            6'd29: o_note = NOTE_W'(TONE_D);
            6'd30: o_note = NOTE_W'(TONE_C);
            6'd31: o_note = NOTE_W'(TONE_C);
            default: o_note = '0;
        endcase
    end

endmodule

// File: rtl/piezo_sound_arbiter.sv
// Fixed-priority arbiter sharing one piezo divider among melody requesters;
// plays the winning melody note by note on a beat tick, with preemption.
module piezo_sound_arbiter
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned BEAT_DIV = 125000,
    parameter int unsigned NOTE_W   = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               cancel,
    output logic [NOTE_W-1:0]  half_period,
    output logic               tone_en,
    output logic               busy,
    output logic [1:0]         active_id,
    output logic               done,
    output logic [1:0]         done_id
);
    import piezo_pkg::*;

    localparam int unsigned CNT_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BEAT_DIV - 1);

    arb_state_e         r_state, w_state_next;
    logic [NUM_REQ-1:0] r_pending, w_pending_next;
    logic [CNT_W-1:0]   r_beat_cnt, w_beat_next;
    logic [3:0]         r_note_idx, w_note_next;
    logic [NOTE_W-1:0]  r_half, w_half_next;
    logic               r_tone_en, w_tone_next;
    logic               r_busy, w_busy_next;
    logic [1:0]         r_active, w_active_next;
    logic               r_done, w_done_next;
    logic [1:0]         r_done_id, w_done_id_next;

    logic [1:0]         w_hi_id;
    logic               w_boundary, w_last, w_preempt, w_load, w_advance;
    logic [5:0]         w_rom_addr;
    logic [NOTE_W-1:0]  w_rom_note;

    always_comb begin
        w_hi_id = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (r_pending[i]) w_hi_id = 2'(i);
        end
    end

    assign w_boundary = (r_beat_cnt == CNT_MAX);
    assign w_last     = ({1'b0, r_note_idx} == (mel_len(r_active) - 5'd1));
    assign w_preempt  = (|r_pending) && (w_hi_id > r_active);
    // A new melody is loaded from idle, on preemption, or chained after the last note.
    assign w_load     = !cancel && (((r_state == StIdle) && (|r_pending)) ||
                        ((r_state == StPlay) && w_boundary && (|r_pending) &&
                         (w_preempt || w_last)));
    assign w_advance  = !cancel && (r_state == StPlay) && w_boundary && !w_preempt && !w_last;
    assign w_rom_addr = w_load ? mel_start(w_hi_id)
                               : mel_start(r_active) + {2'b00, r_note_idx} + 6'd1;

    piezo_melody_rom #(
        .NOTE_W (NOTE_W)
    ) u_rom (
        .i_addr (w_rom_addr),
        .o_note (w_rom_note)
    );

    always_comb begin
        w_state_next   = r_state;
        w_pending_next = r_pending | req;
        w_beat_next    = r_beat_cnt;
        w_note_next    = r_note_idx;
        w_half_next    = r_half;
        w_busy_next    = r_busy;
        w_active_next  = r_active;
        w_done_next    = 1'b0;
        w_done_id_next = '0;

        if (cancel) begin
            w_state_next   = StIdle;
            w_pending_next = '0;
            w_beat_next    = '0;
            w_note_next    = '0;
            w_half_next    = '0;
            w_busy_next    = 1'b0;
            w_active_next  = '0;
        end else begin
            unique case (r_state)
                StIdle: w_beat_next = '0;
                StPlay: begin
                    if (w_boundary) begin
                        w_beat_next = '0;
                        if (!w_preempt && w_last) begin
                            w_done_next    = 1'b1;
                            w_done_id_next = r_active;
                            if (!(|r_pending)) begin
                                w_state_next  = StIdle;
                                w_note_next   = '0;
                                w_half_next   = '0;
                                w_busy_next   = 1'b0;
                                w_active_next = '0;
                            end
                        end
                    end else begin
                        w_beat_next = r_beat_cnt + CNT_W'(1);
                    end
                end
                default: w_state_next = StIdle;
            endcase

            if (w_load) begin
                w_state_next   = StPlay;
                w_pending_next = (r_pending & ~(NUM_REQ'(1) << w_hi_id)) | req;
                w_beat_next    = '0;
                w_note_next    = '0;
                w_half_next    = w_rom_note;
                w_busy_next    = 1'b1;
                w_active_next  = w_hi_id;
            end else if (w_advance) begin
                w_note_next = r_note_idx + 4'd1;
                w_half_next = w_rom_note;
            end
        end

        w_tone_next = w_busy_next && (w_half_next != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_pending  <= '0;
            r_beat_cnt <= '0;
            r_note_idx <= '0;
            r_half     <= '0;
            r_tone_en  <= 1'b0;
            r_busy     <= 1'b0;
            r_active   <= '0;
            r_done     <= 1'b0;
            r_done_id  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_pending  <= w_pending_next;
            r_beat_cnt <= w_beat_next;
            r_note_idx <= w_note_next;
            r_half     <= w_half_next;
            r_tone_en  <= w_tone_next;
            r_busy     <= w_busy_next;
            r_active   <= w_active_next;
            r_done     <= w_done_next;
            r_done_id  <= w_done_id_next;
        end
    end

    assign half_period = r_half;
    assign tone_en     = r_tone_en;
    assign busy        = r_busy;
    assign active_id   = r_active;
    assign done        = r_done;
    assign done_id     = r_done_id;

endmodule

// File: tb/tb_piezo_sound_arbiter.sv
// Bench for piezo_sound_arbiter: vector table, directed corner sequences and
// random traffic checked against a note-queue reference model.
module tb_piezo_sound_arbiter;

    localparam int BEAT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic       cancel = 1'b0;
    logic [9:0] half_period;
    logic       tone_en, busy, done;
    logic [1:0] active_id, done_id;

    piezo_sound_arbiter #(
        .NUM_REQ  (4),
        .BEAT_DIV (BEAT),
        .NOTE_W   (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .cancel      (cancel),
        .half_period (half_period),
        .tone_en     (tone_en),
        .busy        (busy),
        .active_id   (active_id),
        .done        (done),
        .done_id     (done_id)
    );

    always #5 clk = ~clk;

    wire [16:0] dut_vec = {half_period, tone_en, busy, active_id, done, done_id};

    int n_total = 0;
    int n_pass  = 0;

    // Melody contents written out from the tone table.
    int mel0[2]  = '{254, 0};
    int mel1[8]  = '{254, 0, 254, 0, 254, 254, 0, 0};
    int mel2[16] = '{127, 0, 127, 0, 127, 127, 0, 0, 100, 0, 127, 0, 142, 0, 160, 0};
    int mel3[8]  = '{320, 358, 378, 424, 478, 478, 0, 0};

    // Reference model: remaining notes of the playing melody as a queue.
    bit [3:0] m_pend;
    bit       m_play;
    int       m_id;
    int       m_notes[$];
    int       m_left;
    bit       m_done;
    int       m_done_id;

    function automatic int mel_len(int id);
        case (id)
            0: return 2;
            1: return 8;
            2: return 16;
            default: return 8;
        endcase
    endfunction

    function automatic int mel_note(int id, int i);
        case (id)
            0: return mel0[i];
            1: return mel1[i];
            2: return mel2[i];
            default: return mel3[i];
        endcase
    endfunction

    function automatic int top_pending();
        for (int i = 3; i >= 0; i--) if (m_pend[i]) return i;
        return -1;
    endfunction

    function automatic void m_start(int k);
        m_pend[k] = 1'b0;
        m_notes.delete();
        for (int i = 0; i < mel_len(k); i++) m_notes.push_back(mel_note(k, i));
        m_left = BEAT;
        m_play = 1'b1;
        m_id   = k;
    endfunction

    function automatic void m_reset();
        m_pend = '0; m_play = 1'b0; m_id = 0; m_notes.delete();
        m_left = 0; m_done = 1'b0; m_done_id = 0;
    endfunction

    function automatic void m_edge(bit [3:0] r, bit c);
        int t;
        m_done = 1'b0;
        m_done_id = 0;
        if (c) begin
            m_pend = '0; m_play = 1'b0; m_notes.delete();
            return;
        end
        t = top_pending();
        if (!m_play) begin
            if (t >= 0) m_start(t);
        end else begin
            m_left--;
            if (m_left == 0) begin
                if (t > m_id) m_start(t);
                else if (m_notes.size() == 1) begin
                    m_done = 1'b1;
                    m_done_id = m_id;
                    if (t >= 0) m_start(t);
                    else begin m_play = 1'b0; m_notes.delete(); end
                end else begin
                    void'(m_notes.pop_front());
                    m_left = BEAT;
                end
            end
        end
        m_pend |= r;
    endfunction

    function automatic logic [16:0] m_expect();
        logic [9:0] h;
        h = m_play ? 10'(m_notes[0]) : 10'd0;
        return {h, m_play && (h != 0), m_play, m_play ? 2'(m_id) : 2'd0, m_done, 2'(m_done_id)};
    endfunction

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic cycle(input bit [3:0] r, input bit c);
        req = r;
        cancel = c;
        @(posedge clk);
        m_edge(r, c);
        #1;
        check("model", dut_vec, m_expect());
        req = '0;
        cancel = 1'b0;
    endtask

    task automatic run_until_done(input string name, input int budget, output int taken);
        taken = 0;
        do begin
            cycle(4'd0, 1'b0);
            taken++;
        end while (!done && taken < budget);
        if (!done) check_int({name, "_timeout"}, taken, -1);
    endtask

    typedef struct {
        logic [3:0] req;
        logic [9:0] half;
        logic       busy;
        logic       done;
        logic [1:0] done_id;
    } vec_t;

    vec_t tbl[11];
    int   taken, seen, first_t, gap, t_now;
    logic [16:0] exp_v;

    initial begin
        m_reset();
        #1;
        check("reset_state", dut_vec, 17'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: click melody, cycle by cycle.
        tbl[0] = '{4'b0001, 10'd0, 1'b0, 1'b0, 2'd0};
        for (int i = 1; i <= 4; i++) tbl[i] = '{4'b0000, 10'd254, 1'b1, 1'b0, 2'd0};
        for (int i = 5; i <= 8; i++) tbl[i] = '{4'b0000, 10'd0, 1'b1, 1'b0, 2'd0};
        tbl[9]  = '{4'b0000, 10'd0, 1'b0, 1'b1, 2'd0};
        tbl[10] = '{4'b0000, 10'd0, 1'b0, 1'b0, 2'd0};
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].req, 1'b0);
            exp_v = {tbl[i].half, tbl[i].busy && (tbl[i].half != 0), tbl[i].busy, 2'd0,
                     tbl[i].done, tbl[i].done_id};
            check("click_table", dut_vec, exp_v);
        end

        // 2: two simultaneous requests chain with no idle gap.
        cycle(4'b0011, 1'b0);
        run_until_done("chain1", 80, taken);
        check_int("chain1_id", done_id, 1);
        check_int("chain1_len", taken, 33);
        check_int("chain_next_id", active_id, 0);
        check_int("chain_next_half", half_period, 254);
        run_until_done("chain0", 40, taken);
        check_int("chain0_id", done_id, 0);
        repeat (3) cycle(4'd0, 1'b0);

        // 3: game-over preempts click at the beat boundary.
        cycle(4'b0001, 1'b0);
        cycle(4'd0, 1'b0);
        cycle(4'd0, 1'b0);
        cycle(4'b1000, 1'b0);
        taken = 0;
        while (half_period != 10'd320 && taken < 10) begin
            check_int("preempt_hold", half_period, 254);
            cycle(4'd0, 1'b0);
            taken++;
        end
        check_int("preempt_active", active_id, 3);
        run_until_done("gameover", 60, taken);
        check_int("gameover_id", done_id, 3);
        check_int("gameover_len", taken, 32);
        repeat (3) cycle(4'd0, 1'b0);

        // 4: cancel beats a same-cycle request.
        cycle(4'b0100, 1'b0);
        repeat (6) cycle(4'd0, 1'b0);
        cycle(4'b0010, 1'b1);
        check("cancel_zero", dut_vec, 17'd0);
        seen = 0;
        repeat (40) begin
            cycle(4'd0, 1'b0);
            if (busy || done) seen++;
        end
        check_int("cancel_quiet", seen, 0);

        // 5: asynchronous reset between edges mid-note.
        cycle(4'b1000, 1'b0);
        repeat (5) cycle(4'd0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("async_reset", dut_vec, 17'd0);
        m_reset();
        #2 rst = 1'b0;
        repeat (10) cycle(4'd0, 1'b0);

        // 6: re-request of the playing melody replays it back to back.
        cycle(4'b0010, 1'b0);
        repeat (10) cycle(4'd0, 1'b0);
        cycle(4'b0010, 1'b0);
        seen = 0; first_t = 0; gap = 0;
        for (int i = 0; i < 90; i++) begin
            cycle(4'd0, 1'b0);
            if (done) begin
                check_int("replay_id", done_id, 1);
                if (seen == 0) first_t = i; else gap = i - first_t;
                seen++;
            end
        end
        check_int("replay_count", seen, 2);
        check_int("replay_gap", gap, 32);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            t_now = $urandom_range(0, 19);
            cycle((t_now == 0) ? 4'($urandom) : 4'd0, $urandom_range(0, 299) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
